// File: rtl/md_pad_responder.sv
// md_pad_responder: the pad side of the Mega Drive DB9 protocol. It follows the host's TH select
// line, counts TH-low pulses for the 6-button sequence and drives active-low data pins from btn.
module md_pad_responder #(
  parameter int SIX_BUTTON     = 1,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        th_in,
  input  logic [11:0] btn,
  output logic [5:0]  pad_out,
  output logic [2:0]  phase
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_TERM = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4
  } phase_e;

  logic          th_meta_r;
  logic          th_sync_r;
  logic          th_dly_r;
  logic          fall_s;
  logic          rise_s;
  phase_e        phase_r;
  phase_e        phase_nxt_s;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_nxt_s;
  logic [5:0]    map_s;
  logic [5:0]    pad_r;

  // TH synchroniser plus one delay stage; all preset high so reset release never looks like a fall.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      th_meta_r <= 1'b1;
      th_sync_r <= 1'b1;
      th_dly_r  <= 1'b1;
    end else begin
      th_meta_r <= th_in;
      th_sync_r <= th_meta_r;
      th_dly_r  <= th_sync_r;
    end
  end

  assign fall_s = th_dly_r & ~th_sync_r;
  assign rise_s = ~th_dly_r & th_sync_r;

  // Phase counter and idle timer registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      phase_r <= PH0;
      timer_r <= '0;
    end else begin
      phase_r <= phase_nxt_s;
      timer_r <= timer_nxt_s;
    end
  end

  // Next phase/timer: a TH edge always beats the timeout, and the timer idles at zero in phase 0.
  always_comb begin
    phase_nxt_s = phase_r;
    timer_nxt_s = timer_r;
    if (SIX_BUTTON != 0) begin
      if (fall_s) begin
        timer_nxt_s = '0;
        case (phase_r)
          PH0:     phase_nxt_s = PH1;
          PH1:     phase_nxt_s = PH2;
          PH2:     phase_nxt_s = PH3;
          PH3:     phase_nxt_s = PH4;
          PH4:     phase_nxt_s = PH1;
          default: phase_nxt_s = PH1;
        endcase
      end else if (rise_s) begin
        timer_nxt_s = '0;
      end else if (phase_r == PH0) begin
        timer_nxt_s = '0;
      end else if (timer_r == TIMER_TERM) begin
        phase_nxt_s = PH0;
        timer_nxt_s = '0;
      end else begin
        timer_nxt_s = timer_r + TW'(1);
      end
    end else begin
      phase_nxt_s = PH0;
      timer_nxt_s = '0;
    end
  end

  // Positive-logic pin map selected by the synchronised TH level and the current phase.
  always_comb begin
    map_s = 6'b000000;
    if (th_sync_r) begin
      if (phase_r == PH3) begin
        map_s = {btn[5], btn[4], btn[8], btn[9], btn[10], btn[11]};
      end else begin
        map_s = {btn[5], btn[4], btn[0], btn[1], btn[2], btn[3]};
      end
    end else begin
      case (phase_r)
        PH3:     map_s = {btn[7], btn[6], 4'b0000};
        PH4:     map_s = {btn[7], btn[6], 4'b1111};
        default: map_s = {btn[7], btn[6], 2'b00, btn[2], btn[3]};
      endcase
    end
  end

  // Output register; pins are active low and idle released.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pad_r <= 6'h3F;
    end else begin
      pad_r <= ~map_s;
    end
  end

  assign pad_out = pad_r;
  assign phase   = phase_r;

endmodule

// File: tb/tb_md_pad_responder.sv
// Bench for md_pad_responder: fixed vector table, hand-timed latency/timeout/reset sequences,
// then random TH/button traffic against a behavioural pad model (6-button and 3-button builds).
module tb_md_pad_responder;

  localparam int TO = 64;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        th_in;
  logic [11:0] btn;
  logic [5:0]  pad_out;
  logic [2:0]  phase;
  logic [5:0]  pad_out_3b;
  logic [2:0]  phase_3b;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  md_pad_responder #(.SIX_BUTTON(1), .TIMEOUT_CYCLES(TO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .th_in(th_in), .btn(btn),
    .pad_out(pad_out), .phase(phase)
  );

  md_pad_responder #(.SIX_BUTTON(0), .TIMEOUT_CYCLES(TO)) dut_3b (
    .clk_sys(clk_sys), .reset_n(reset_n), .th_in(th_in), .btn(btn),
    .pad_out(pad_out_3b), .phase(phase_3b)
  );

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What the pad presents on D[5:0] (positive logic) for a TH level, pulse count and buttons.
  function automatic logic [5:0] ref_map(input logic th, input int ph, input logic [11:0] b);
    if (th) begin
      if (ph == 3) return {b[5], b[4], b[8], b[9], b[10], b[11]};
      return {b[5], b[4], b[0], b[1], b[2], b[3]};
    end
    if (ph == 3) return {b[7], b[6], 4'b0000};
    if (ph == 4) return {b[7], b[6], 4'b1111};
    return {b[7], b[6], 2'b00, b[2], b[3]};
  endfunction

  // Behavioural model: the pad reacts to TH as seen two clocks late; it counts TH-low pulses
  // 1..4 cyclically and forgets the count after TO quiet clocks.
  logic [2:0] hist_q  = 3'b111;
  int         m_phase = 0;
  int         m_idle  = 0;
  logic [5:0] m_pad   = 6'h3F;
  logic [5:0] m_pad3  = 6'h3F;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hist_q  <= 3'b111;
      m_phase <= 0;
      m_idle  <= 0;
      m_pad   <= 6'h3F;
      m_pad3  <= 6'h3F;
    end else begin
      hist_q <= {hist_q[1:0], th_in};
      m_pad  <= ~ref_map(hist_q[1], m_phase, btn);
      m_pad3 <= ~ref_map(hist_q[1], 0, btn);
      if (hist_q[1] != hist_q[2]) begin
        m_idle <= 0;
        if (!hist_q[1]) m_phase <= (m_phase < 4) ? m_phase + 1 : 1;
      end else if (m_phase != 0) begin
        if (m_idle + 1 == TO) begin
          m_phase <= 0;
          m_idle  <= 0;
        end else begin
          m_idle <= m_idle + 1;
        end
      end
    end
  end

  typedef struct {
    logic        th;
    logic [11:0] b;
    logic [5:0]  pad;
    logic [2:0]  ph;
  } vec_t;

  vec_t vt[12];

  initial begin
    int hold;

    vt[0]  = '{1'b1, 12'h009, 6'b110110, 3'd0};
    vt[1]  = '{1'b0, 12'h009, 6'b111110, 3'd1};
    vt[2]  = '{1'b1, 12'h0FF, 6'b000000, 3'd1};
    vt[3]  = '{1'b0, 12'h0C0, 6'b001111, 3'd2};
    vt[4]  = '{1'b1, 12'h900, 6'b111111, 3'd2};
    vt[5]  = '{1'b0, 12'h900, 6'b111111, 3'd3};
    vt[6]  = '{1'b1, 12'h900, 6'b110110, 3'd3};
    vt[7]  = '{1'b1, 12'hE30, 6'b001000, 3'd3};
    vt[8]  = '{1'b0, 12'h000, 6'b110000, 3'd4};
    vt[9]  = '{1'b1, 12'h00C, 6'b111100, 3'd4};
    vt[10] = '{1'b0, 12'h000, 6'b111111, 3'd1};
    vt[11] = '{1'b1, 12'h002, 6'b111011, 3'd1};

    // Reset state and a quiet release.
    reset_n = 1'b0;
    th_in   = 1'b1;
    btn     = 12'hFFF;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("reset_pad", pad_out, 6'h3F);
    chk("reset_phase", {3'b000, phase}, 6'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    chk("release_phase", {3'b000, phase}, 6'd0);
    chk("release_pad", pad_out, 6'b000000);

    // Table: each entry holds TH/btn long enough for the 3-clock path to settle.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_sys);
      th_in = vt[i].th;
      btn   = vt[i].b;
      repeat (4) @(negedge clk_sys);
      chk($sformatf("vec%0d_pad", i), pad_out, vt[i].pad);
      chk($sformatf("vec%0d_phase", i), {3'b000, phase}, {3'b000, vt[i].ph});
      chk($sformatf("vec%0d_phase3b", i), {3'b000, phase_3b}, 6'd0);
    end

    // Latency: btn reaches the pins in 1 clock, a TH fall in 3 clocks (phase 1 -> 2).
    btn = 12'h009;
    @(negedge clk_sys);
    chk("btn_lat1_pad", pad_out, 6'b110110);
    th_in = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("th_lat2_pad", pad_out, 6'b110110);
    chk("th_lat2_phase", {3'b000, phase}, 6'd1);
    @(negedge clk_sys);
    chk("th_lat3_pad", pad_out, 6'b111110);
    chk("th_lat3_phase", {3'b000, phase}, 6'd2);

    // Timeout: phase 2 survives TO+2 clocks after the rise is driven, clears on the next.
    @(negedge clk_sys);
    th_in = 1'b1;
    repeat (TO + 2) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("timeout_minus1_phase", {3'b000, phase}, 6'd2);
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("timeout_phase", {3'b000, phase}, 6'd0);

    // Fall landing on the timeout terminal count: edge wins, 2 -> 3.
    th_in = 1'b0;
    repeat (4) @(negedge clk_sys);
    th_in = 1'b1;
    repeat (4) @(negedge clk_sys);
    th_in = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("edge_win_pre_phase", {3'b000, phase}, 6'd2);
    th_in = 1'b1;
    repeat (TO) @(posedge clk_sys);
    @(negedge clk_sys);
    th_in = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("edge_win_phase", {3'b000, phase}, 6'd3);
    repeat (10) @(negedge clk_sys);
    chk("edge_win_hold_phase", {3'b000, phase}, 6'd3);

    // Reset in the middle of the sequence (phase 3), then the first fall gives phase 1.
    reset_n = 1'b0;
    #1;
    chk("midreset_phase", {3'b000, phase}, 6'd0);
    chk("midreset_pad", pad_out, 6'h3F);
    th_in = 1'b1;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("postreset_phase", {3'b000, phase}, 6'd0);
    th_in = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("postreset_fall_phase", {3'b000, phase}, 6'd1);

    // Random TH pulse trains and buttons against the model, both builds.
    hold = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_sys);
      chk("rand_pad", pad_out, m_pad);
      chk("rand_phase", {3'b000, phase}, 6'(m_phase));
      chk("rand_pad_3b", pad_out_3b, m_pad3);
      chk("rand_phase_3b", {3'b000, phase_3b}, 6'd0);
      if (hold == 0) begin
        th_in = ~th_in;
        hold  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 20, TO + 30))
                                            : int'($urandom_range(0, 7));
      end else begin
        hold--;
      end
      btn = 12'($urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
